// File: rtl/set_bit_iter_pkg.sv
// Shared types and constants for the set-bit iterator and its circular search unit.
package set_bit_iter_pkg;

    localparam int unsigned W_DEF = 32;
    localparam int unsigned LW    = $clog2(W_DEF);

    typedef enum logic {
        IDLE = 1'b0,
        ITER = 1'b1
    } state_t;

endpackage

// File: rtl/set_bit_iter_s.sv
// Combinational circular search: first set bit of x_i at or above pos_i, wrapping
// to the lowest set bit below pos_i. Result is given one-hot and encoded.
module set_bit_iter_s
    import set_bit_iter_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0]         x_i,
    input  logic [$clog2(W)-1:0] pos_i,
    output logic [W-1:0]         y_o,
    output logic [$clog2(W)-1:0] y_enc_o
);

    localparam int IW = $clog2(W);

    logic          found;
    logic [IW-1:0] idx;

    // Walk the vector starting at pos_i; the IW-bit add wraps the index naturally.
    always_comb begin
        found   = 1'b0;
        idx     = '0;
        y_enc_o = '0;
        for (int i = 0; i < W; i++) begin
            idx = pos_i + IW'(i);
            if (!found && x_i[idx]) begin
                found   = 1'b1;
                y_enc_o = idx;
            end
        end
        y_o = found ? (W'(1) << y_enc_o) : '0;
    end

endmodule

// File: rtl/set_bit_iter.sv
// Sequential iterator over the set bits of a vector: one index per output
// handshake, in circular order from a given start position.
module set_bit_iter
    import set_bit_iter_pkg::*;
#(
    parameter int W = 32
) (
    input  logic                 clk,
    input  logic                 arst_n,
    input  logic                 in_vld_i,
    output logic                 in_rdy_o,
    input  logic [W-1:0]         in_x_i,
    input  logic [$clog2(W)-1:0] in_pos_i,
    input  logic                 abort_i,
    output logic                 out_vld_o,
    input  logic                 out_rdy_i,
    output logic [$clog2(W)-1:0] out_idx_o,
    output logic                 out_last_o,
    output logic                 done_o
);

    localparam int IW = $clog2(W);

    state_t        state_q, state_d;
    logic [W-1:0]  mask_r, mask_d;
    logic [IW-1:0] cur_r, cur_d;
    logic          done_r, done_d;

    logic [W-1:0]  y;
    logic [IW-1:0] y_enc;
    logic          last;

    set_bit_iter_s #(.W(W)) u_search (
        .x_i     (mask_r),
        .pos_i   (cur_r),
        .y_o     (y),
        .y_enc_o (y_enc)
    );

    // Final beat when removing the current bit leaves the mask empty.
    assign last       = ((mask_r & ~y) == '0);
    assign in_rdy_o   = (state_q == IDLE);
    assign out_vld_o  = (state_q == ITER);
    assign out_idx_o  = y_enc;
    assign out_last_o = last;
    assign done_o     = done_r;

    always_comb begin
        state_d = state_q;
        mask_d  = mask_r;
        cur_d   = cur_r;
        done_d  = 1'b0;
        if (abort_i) begin
            state_d = IDLE;
            mask_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_vld_i) begin
                        mask_d = in_x_i;
                        cur_d  = in_pos_i;
                        if (in_x_i != '0) begin
                            state_d = ITER;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                ITER: begin
                    if (out_rdy_i) begin
                        mask_d = mask_r & ~y;
                        cur_d  = y_enc + IW'(1);
                        if (last) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state_q <= IDLE;
            mask_r  <= '0;
            cur_r   <= '0;
            done_r  <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_r  <= mask_d;
            cur_r   <= cur_d;
            done_r  <= done_d;
        end
    end

    a_vld_has_bits: assert property (@(posedge clk) disable iff (!arst_n)
        out_vld_o |-> (|mask_r));
    a_rdy_vld_excl: assert property (@(posedge clk) disable iff (!arst_n)
        !(in_rdy_o && out_vld_o));

endmodule

// File: tb/tb_set_bit_iter.sv
// Bench for set_bit_iter: directed W=8 cases and randomized W=32 runs against
// a circular-order reference list built from the input vector.
module tb_set_bit_iter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        arst_n, in_vld, abort, out_rdy, sel32;
    logic [31:0] in_x;
    logic [4:0]  in_pos;

    logic       rdy8, vld8, last8, done8;
    logic [2:0] idx8;
    logic       rdy32, vld32, last32, done32;
    logic [4:0] idx32;

    logic       o_rdy, o_vld, o_last, o_done;
    logic [4:0] o_idx;

    int checks = 0;
    int errors = 0;

    set_bit_iter #(.W(8)) dut8 (
        .clk        (clk),
        .arst_n     (arst_n),
        .in_vld_i   (in_vld && !sel32),
        .in_rdy_o   (rdy8),
        .in_x_i     (in_x[7:0]),
        .in_pos_i   (in_pos[2:0]),
        .abort_i    (abort),
        .out_vld_o  (vld8),
        .out_rdy_i  (out_rdy),
        .out_idx_o  (idx8),
        .out_last_o (last8),
        .done_o     (done8)
    );

    set_bit_iter #(.W(32)) dut32 (
        .clk        (clk),
        .arst_n     (arst_n),
        .in_vld_i   (in_vld && sel32),
        .in_rdy_o   (rdy32),
        .in_x_i     (in_x),
        .in_pos_i   (in_pos),
        .abort_i    (abort),
        .out_vld_o  (vld32),
        .out_rdy_i  (out_rdy),
        .out_idx_o  (idx32),
        .out_last_o (last32),
        .done_o     (done32)
    );

    always_comb begin
        o_rdy  = sel32 ? rdy32  : rdy8;
        o_vld  = sel32 ? vld32  : vld8;
        o_last = sel32 ? last32 : last8;
        o_done = sel32 ? done32 : done8;
        o_idx  = sel32 ? idx32  : {2'b00, idx8};
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic check_idle(input string tag, input logic exp_done);
        check({tag, "_vld"},  32'(o_vld),  32'd0);
        check({tag, "_rdy"},  32'(o_rdy),  32'd1);
        check({tag, "_done"}, 32'(o_done), 32'(exp_done));
    endtask

    task automatic load(input logic [31:0] x, input int pos);
        in_vld = 1'b1;
        in_x   = x;
        in_pos = 5'(pos);
        @(negedge clk);
        in_vld = 1'b0;
    endtask

    // Expected beats: set bits visited circularly from pos.
    task automatic run(input string tag, input logic [31:0] x, input int pos, input int w,
                       input logic [15:0] pat, input bit rand_rdy);
        int  exp_q[$];
        int  k;
        int  cyc;
        int  n;
        logic r;
        for (int i = 0; i < w; i++) begin
            if (x[(pos + i) % w]) exp_q.push_back((pos + i) % w);
        end
        n   = exp_q.size();
        k   = 0;
        cyc = 0;
        load(x, pos);
        while (k < n && cyc < 300) begin
            check({tag, "_vld"},  32'(o_vld),  32'd1);
            check({tag, "_rdy"},  32'(o_rdy),  32'd0);
            check({tag, "_idx"},  32'(o_idx),  32'(exp_q[k]));
            check({tag, "_last"}, 32'(o_last), 32'(k == n - 1));
            check({tag, "_done"}, 32'(o_done), 32'd0);
            r = rand_rdy ? 1'($urandom_range(0, 1)) : pat[cyc % 16];
            out_rdy = r;
            @(negedge clk);
            if (r) k++;
            cyc++;
        end
        out_rdy = 1'b0;
        check({tag, "_beats"}, 32'(k), 32'(n));
        check_idle({tag, "_end"}, 1'b1);
        @(negedge clk);
        check_idle({tag, "_post"}, 1'b0);
    endtask

    // Start a 0x0F iteration, take two beats, then kill it by abort or reset.
    task automatic interrupt(input string tag, input bit use_reset);
        load(32'h0F, 0);
        for (int b = 0; b < 2; b++) begin
            check({tag, "_idx"}, 32'(o_idx), 32'(b));
            out_rdy = 1'b1;
            @(negedge clk);
        end
        out_rdy = 1'b0;
        check({tag, "_mid"}, 32'(o_vld), 32'd1);
        if (use_reset) arst_n = 1'b0;
        else begin
            abort  = 1'b1;
            in_vld = 1'b1;
            in_x   = 32'hF0;
        end
        @(negedge clk);
        arst_n = 1'b1;
        abort  = 1'b0;
        in_vld = 1'b0;
        check_idle({tag, "_kill"}, 1'b0);
        @(negedge clk);
        check_idle({tag, "_kill2"}, 1'b0);
    endtask

    initial begin
        arst_n  = 1'b0;
        in_vld  = 1'b0;
        abort   = 1'b0;
        out_rdy = 1'b0;
        sel32   = 1'b0;
        in_x    = '0;
        in_pos  = '0;
        repeat (2) @(negedge clk);
        arst_n = 1'b1;
        check_idle("reset8", 1'b0);
        sel32 = 1'b1;
        check_idle("reset32", 1'b0);
        sel32 = 1'b0;

        run("x90", 32'h90, 5, 8, 16'hFFFF, 1'b0);
        run("x00", 32'h00, 3, 8, 16'hFFFF, 1'b0);
        run("xFF", 32'hFF, 0, 8, 16'hFFFF, 1'b0);
        run("x81", 32'h81, 7, 8, 16'h0024, 1'b0);

        interrupt("abort", 1'b0);
        run("after_abort", 32'h0F, 0, 8, 16'hFFFF, 1'b0);
        interrupt("rstmid", 1'b1);
        run("after_rst", 32'h0F, 0, 8, 16'hFFFF, 1'b0);

        sel32 = 1'b1;
        for (int t = 0; t < 40; t++) begin
            logic [31:0] x;
            x = $urandom;
            if (t % 3 == 1) x = x & $urandom & $urandom;
            if (t % 10 == 9) x = 32'h8000_0000 >> $urandom_range(0, 31);
            run("rand32", x, int'($urandom_range(0, 31)), 32, 16'h0000, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
